dma_engine: RTL
===============

# dma_engine

Bus-mastering copy engine for the blue memory map: the initiator counterpart to the memory controller's responder port. The CPU programs four registers through the memory controller's DMA window (`dma_en`/`dma_mode`). A write to the amount register starts the copy. The engine requests the shared memory bus, reads each source word through the same `memaddr`/`memdata` path the CPU uses, and writes it to the destination, so sprite, tile, palette and program RAM can be filled without CPU loads and stores.

## Interface
Parameters:
- `ADDR_W`, 16: memory-map address width.
- `DATA_W`, 16: bus data width.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous and active-low.
- `reg_en`  in  1  register window select; driven by the memory controller's `dma_en`.
- `reg_sel`  in  2  register index; driven by `dma_mode`. 0 SRC_L, 1 SRC_U, 2 DST, 3 AMT.
- `reg_write`  in  1  CPU write strobe.
- `reg_wdata`  in  16  CPU write data.
- `reg_rdata`  out  16  register readback, combinational from `reg_sel`.
- `busy`  out  1  high from the AMT write until the DONE state.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `bus_req`  out  1  request for bus ownership.
- `bus_grant`  in  1  arbiter grant. While high, the top-level muxes the `bus_*` outputs onto `memaddr`, `memwrite` and `writedata`.
- `bus_addr`  out  16  address driven while granted.
- `bus_write`  out  1  write strobe.
- `bus_wdata`  out  16  write data.
- `bus_rdata`  in  16  the memory controller's `memdata`.

## Operation
Registers:
- SRC_L: current source address.
- SRC_U: bit 0 is HOLD. When set, the source does not increment, which gives a fill from one location (for example RNG). Bits 15:1 read as 0.
- DST: current destination address.
- AMT: words remaining.

Register writes:
- Accepted only when `reg_en && reg_write` and the state is IDLE.
- While busy, all register writes are ignored.
- Writing AMT with a nonzero value starts a transfer.
- Writing AMT = 0 stores 0 and starts nothing: no request is made and no `done` pulse is produced.

FSM states: IDLE, REQ, READ, LATCH, WRITE, DONE.
- IDLE: on a nonzero AMT write, go to REQ.
- REQ: `bus_req` = 1. When `bus_grant` = 1, go to READ.
- READ: drive `bus_addr` = SRC, `bus_write` = 0; go to LATCH.
- LATCH: hold `bus_addr` = SRC; sample `bus_rdata` into the data register at the clock edge; go to WRITE.
- WRITE: drive `bus_addr` = DST, `bus_write` = 1, `bus_wdata` = data register. On exit:
  - DST += 1.
  - SRC += 1, unless HOLD is set.
  - AMT -= 1.
  - If the new AMT is 0, go to DONE; otherwise go to READ.
- DONE: `done` = 1, `bus_req` = 0, `busy` = 0; go to IDLE.

`bus_req` is high in REQ, READ, LATCH and WRITE.

Grant loss:
- If `bus_grant` is low in READ or LATCH, the read is not committed and the state returns to READ for the same word.
- If `bus_grant` is low in WRITE, `bus_write` is forced to 0 and the state holds; the write completes when the grant returns.

Other rules:
- Addresses wrap modulo 2^16; 0xFFFF + 1 = 0x0000. No bounds checking is done.
- Source equal to destination is legal; each word is rewritten with its own value.
- `bus_addr`, `bus_write` and `bus_wdata` are 0 whenever the state is not READ, LATCH or WRITE.

## Timing
Reset:
- Async assertion forces IDLE and clears SRC, HOLD, DST, AMT and the data register to 0.
- `bus_req`, `bus_write`, `busy` and `done` go to 0 immediately, including mid-transfer. A partially written block stays as it is.

Latency:
- AMT written at edge 0: `busy` and `bus_req` are high in cycle 1.
- With the grant already high, the first READ is cycle 2.
- Each word takes 3 cycles (READ, LATCH, WRITE).
- For N words with the grant held: the last write is cycle 1 + 3N, and `done` is high in cycle 2 + 3N.

Source read: the memory map's read data is valid in the cycle after the address is presented. LATCH therefore exists only to wait for that data.

Readback while busy: `reg_rdata` returns the live SRC, DST and remaining AMT.

## Structure
- `dma_pkg` holds the state enum, the register-index constants (`DMA_SEL_SRC_L` = 0 … `DMA_SEL_AMT` = 3) and the HOLD bit position. The memory controller's DMA window decode uses the same constants.
- Single module; no sub-module needed. The top-level bus mux and arbiter are outside this block.

## Test plan
- Basic copy: SRC_L = 0x0100, DST = 0x2000, AMT = 4, memory 0x0100..0x0103 = A1..A4, grant tied high. Expect writes A1..A4 to 0x2000..0x2003 in cycles 4, 7, 10, 13, `done` in cycle 14, and AMT reads back 0.
- Fill: SRC_U = 1 (HOLD), SRC_L = 0x4809, AMT = 3. Expect three reads of 0x4809, writes to DST..DST+2, and SRC_L reads 0x4809 after the transfer.
- Zero and ignored writes: AMT = 0 gives no `bus_req` and no `done`. A DST write during a busy transfer leaves DST's live value unchanged.
- Wrap: DST = 0xFFFF, AMT = 2. Expect writes to 0xFFFF then 0x0000.
- Grant stall: drop `bus_grant` for 5 cycles during LATCH, then during WRITE. Expect the read to be re-issued, no `bus_write` while the grant is low, and the correct data written after the grant returns.
- Async reset mid-transfer: assert `rst` low between clock edges during WRITE of word 2 of 4. Expect `bus_req` and `bus_write` to drop 0 immediately, and all registers to read 0 after release.

Source files
------------

// File: rtl/dma_engine_pkg.sv
//==============================================================================
// Module      : dma_pkg
// Description : Shared state encoding and register-window constants for the
//               DMA copy engine and the memory controller's DMA window decode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } dma_state_t;

    localparam logic [1:0] DMA_SEL_SRC_L = 2'd0;
    localparam logic [1:0] DMA_SEL_SRC_U = 2'd1;
    localparam logic [1:0] DMA_SEL_DST   = 2'd2;
    localparam logic [1:0] DMA_SEL_AMT   = 2'd3;

    localparam int DMA_HOLD_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/dma_engine.sv
//==============================================================================
// Module      : dma_engine
// Description : Bus-mastering word copy engine; reads each source word over the
//               shared memory bus and writes it to the destination.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_en,
    input  logic [1:0]        reg_sel,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    import dma_pkg::*;

    dma_state_t        r_state;
    dma_state_t        w_next_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic              r_hold;
    logic [DATA_W-1:0] r_amt;
    logic [DATA_W-1:0] r_data;

    logic w_reg_wr;
    logic w_commit_rd;
    logic w_commit_wr;

    // Registers are only writable while idle so a running copy cannot be disturbed.
    assign w_reg_wr    = reg_en && reg_write && (r_state == ST_IDLE);
    assign w_commit_rd = (r_state == ST_LATCH) && bus_grant;
    assign w_commit_wr = (r_state == ST_WRITE) && bus_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_hold  <= 1'b0;
            r_amt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_reg_wr) begin
                case (reg_sel)
                    DMA_SEL_SRC_L: r_src  <= reg_wdata[ADDR_W-1:0];
                    DMA_SEL_SRC_U: r_hold <= reg_wdata[DMA_HOLD_BIT];
                    DMA_SEL_DST:   r_dst  <= reg_wdata[ADDR_W-1:0];
                    DMA_SEL_AMT:   r_amt  <= reg_wdata;
                    default:       r_amt  <= r_amt;
                endcase
            end
            if (w_commit_rd) begin
                r_data <= bus_rdata;
            end
            if (w_commit_wr) begin
                r_dst <= r_dst + ADDR_W'(1);
                r_amt <= r_amt - DATA_W'(1);
                if (!r_hold) begin
                    r_src <= r_src + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        bus_req      = 1'b0;
        bus_addr     = '0;
        bus_write    = 1'b0;
        bus_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_reg_wr && (reg_sel == DMA_SEL_AMT) && (reg_wdata != '0)) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_grant) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                busy         = 1'b1;
                bus_req      = 1'b1;
                bus_addr     = r_src;
                w_next_state = bus_grant ? ST_LATCH : ST_READ;
            end
            ST_LATCH: begin
                // Read data arrives one cycle after the address; a lost grant re-issues the read.
                busy         = 1'b1;
                bus_req      = 1'b1;
                bus_addr     = r_src;
                w_next_state = bus_grant ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                busy      = 1'b1;
                bus_req   = 1'b1;
                bus_addr  = r_dst;
                bus_wdata = r_data;
                bus_write = bus_grant;
                if (bus_grant) begin
                    w_next_state = (r_amt == DATA_W'(1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            DMA_SEL_SRC_L: reg_rdata = DATA_W'(r_src);
            DMA_SEL_SRC_U: reg_rdata = DATA_W'(r_hold);
            DMA_SEL_DST:   reg_rdata = DATA_W'(r_dst);
            DMA_SEL_AMT:   reg_rdata = r_amt;
            default:       reg_rdata = '0;
        endcase
    end

endmodule

`default_nettype wire
